// File: rtl/f3m_inv_check_pkg.sv
// GF(3^97) verifier shared definitions: field sizes, trit encodings, FSM states, trit helpers.
package f3m_pkg;

  localparam int unsigned M     = 97;
  localparam int unsigned T     = 12;
  localparam int unsigned W     = 2 * M;
  localparam int unsigned CNT_W = 7;

  localparam logic [W-1:0] F3M_ONE = W'(1);

  localparam logic [1:0] F3_0 = 2'b00;
  localparam logic [1:0] F3_1 = 2'b01;
  localparam logic [1:0] F3_2 = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Trit addition mod 3 on the 2-bit encoding
  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  // Trit negation: swap the 1 and 2 encodings, 0 stays 0
  function automatic logic [1:0] f3_neg(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // Scalar trit product s*x
  function automatic logic [1:0] f3_mul(input logic [1:0] x, input logic [1:0] s);
    logic [1:0] r;
    case (s)
      F3_1:    r = x;
      F3_2:    r = f3_neg(x);
      default: r = F3_0;
    endcase
    return r;
  endfunction

  // True if any trit of an element uses the illegal 11 encoding
  function automatic logic f3_has_illegal(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(M); i++) begin
      bad = bad | (x[2*i] & x[2*i+1]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/f3m_inv_check_if.sv
// Operand/result bus between an inverse producer and the f3m_inv_check verifier.
interface f3m_inv_check_if;
  import f3m_pkg::*;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] C;
  logic         busy;
  logic         done;
  logic [W-1:0] P;
  logic         is_one;
  logic         err;

  modport master (output start, A, C, input busy, done, P, is_one, err);
  modport slave  (input start, A, C, output busy, done, P, is_one, err);
endinterface

// File: rtl/f3m_inv_check_mulx_acc.sv
// One Horner step over GF(3^97): acc_next_c = x*acc mod f(x) + s*a, f(x) = x^M + x^T + 2.
module f3m_mulx_acc
  import f3m_pkg::*;
(
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [1:0]   s,
  output logic [W-1:0] acc_next_c
);

  // Trit shifted out of the top; x^M = 2*x^T + 1 folds it back into trit 0 and trit T
  logic [1:0] top_c;
  assign top_c = acc[W-1 -: 2];

  for (genvar i = 0; i < int'(M); i++) begin : g_trit
    logic [1:0] sh_c;
    logic [1:0] fb_c;
    logic [1:0] sa_c;

    if (i == 0) begin : g_lo
      assign sh_c = F3_0;
      assign fb_c = top_c;
    end else if (i == int'(T)) begin : g_tap
      assign sh_c = acc[2*i-1 -: 2];
      assign fb_c = f3_neg(top_c);
    end else begin : g_mid
      assign sh_c = acc[2*i-1 -: 2];
      assign fb_c = F3_0;
    end

    assign sa_c = f3_mul(a[2*i +: 2], s);
    assign acc_next_c[2*i +: 2] = f3_add(f3_add(sh_c, fb_c), sa_c);
  end

endmodule

// File: rtl/f3m_inv_check.sv
// Serial GF(3^97) inverse verifier: P = A*C mod f(x), one trit of C per clock (MSB first),
// flags P == 1. Optional encoding check enabled by F3M_INV_CHECK_ERR_EN.
module f3m_inv_check
  import f3m_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  f3m_inv_check_if.slave    bus
);

  state_t             state, state_nx;
  logic [W-1:0]       a_r, c_r, acc, p_r;
  logic [W-1:0]       acc_next_c;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               busy_r, done_r, one_r;
  logic               load_c, step_c, finish_c;
  logic [1:0]         s_c;

  // Current trit of C, selected by the down-counter
  assign s_c = 2'(c_r >> {cnt, 1'b0});

  f3m_mulx_acc u_mulx_acc (
    .acc        (acc),
    .a          (a_r),
    .s          (s_c),
    .acc_next_c (acc_next_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and datapath controls; start is ignored while RUN
  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nx = RUN;
        load_c   = 1'b1;
      end
      RUN: if (last) begin
        state_nx = DONE;
        finish_c = 1'b1;
      end else begin
        step_c = 1'b1;
      end
      DONE: if (bus.start) begin
        state_nx = RUN;
        load_c   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, Horner accumulation and result capture; last marks the M-th step done
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      c_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      last   <= 1'b0;
      p_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      one_r  <= 1'b0;
    end else if (load_c) begin
      a_r    <= bus.A;
      c_r    <= bus.C;
      acc    <= '0;
      cnt    <= CNT_W'(M - 1);
      last   <= 1'b0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (step_c) begin
      acc  <= acc_next_c;
      cnt  <= cnt - CNT_W'(1);
      last <= (cnt == '0);
    end else if (finish_c) begin
      p_r    <= acc;
      one_r  <= (acc == F3M_ONE);
      busy_r <= 1'b0;
      done_r <= 1'b1;
      last   <= 1'b0;
    end
  end

`ifdef F3M_INV_CHECK_ERR_EN
  logic err_r;

  // Illegal-encoding flag, re-evaluated on every accepted start
  always_ff @(posedge clk) begin
    if (reset)       err_r <= 1'b0;
    else if (load_c) err_r <= f3_has_illegal(bus.A) | f3_has_illegal(bus.C);
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.P      = p_r;
  assign bus.is_one = one_r;

endmodule

// File: tb/tb_f3m_inv_check.sv
// Directed self-checking bench for f3m_inv_check (GF(3^97) inverse verifier).
module tb_f3m_inv_check;
  import f3m_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  f3m_inv_check_if bus ();

  f3m_inv_check dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam int LAT = int'(M) + 1;

  // Drive a one-cycle start; returns just after the sampling edge
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] c);
    @(negedge clk);
    bus.A     = a;
    bus.C     = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done, bounded
  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] c,
                           input logic [W-1:0] exp_p, input logic exp_one);
    int cyc;
    cyc = 0;
    pulse_start(a, c);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b done=%b required busy=1 done=0", name, bus.busy, bus.done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, cyc, LAT);
    end
    checks++;
    if (bus.P !== exp_p) begin
      errors++;
      $display("FAIL %s P: got %h required %h", name, bus.P, exp_p);
    end
    checks++;
    if (bus.is_one !== exp_one || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: is_one=%b busy=%b required is_one=%b busy=0",
               name, bus.is_one, bus.busy, exp_one);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== '0 || bus.is_one !== 1'b0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b is_one=%b err=%b P=%h required all 0",
               bus.busy, bus.done, bus.is_one, bus.err, bus.P);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_products;
    logic [W-1:0] c2, x96, red;
    c2  = (W'(1) << 192) | (W'(1) << 22);
    x96 = W'(1) << 192;
    red = (W'(1) << 25) | W'(1);
    run_check("one_times_one", W'(1), W'(1), W'(1), 1'b1);
    run_check("x_inverse", W'(4), c2, W'(1), 1'b1);
    run_check("x_squared", W'(4), W'(4), W'(16), 1'b0);
    run_check("two_times_two", W'(2), W'(2), W'(1), 1'b1);
    run_check("x96_times_x_reduce", x96, W'(4), red, 1'b0);
  endtask

  task automatic test_back_to_back;
    int cyc;
    cyc = 0;
    pulse_start(W'(1), W'(1));
    wait_done(cyc);
    pulse_start(W'(4), W'(4));
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: done=%b busy=%b required done=0 busy=1", bus.done, bus.busy);
    end
    cyc = 0;
    wait_done(cyc);
    checks++;
    if (cyc !== LAT || bus.P !== W'(16)) begin
      errors++;
      $display("FAIL restart_result: latency=%0d P=%h required %0d and %h", cyc, bus.P, LAT, W'(16));
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    logic [W-1:0] ones;
    ones = {M{2'b01}};
    cyc = 0;
    pulse_start('0, ones);
    repeat (39) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    bus.A     = W'(1);
    bus.C     = W'(1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL ignore_start latency: got %0d required %0d", cyc, LAT);
    end
    checks++;
    if (bus.P !== '0 || bus.is_one !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result: P=%h is_one=%b required 0 0", bus.P, bus.is_one);
    end
  endtask

  task automatic test_reset_mid;
    pulse_start(W'(4), W'(4));
    repeat (49) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== '0 || bus.is_one !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b is_one=%b P=%h required all 0",
               bus.busy, bus.done, bus.is_one, bus.P);
    end
    // reset and start on the same edge: reset wins, block stays idle
    @(negedge clk);
    bus.A     = W'(1);
    bus.C     = W'(1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    run_check("after_reset", W'(2), W'(2), W'(1), 1'b1);
  endtask

  task automatic test_err;
    int cyc;
    logic exp_err;
`ifdef F3M_INV_CHECK_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cyc = 0;
    pulse_start(W'(12'hC00), W'(1));
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL err_illegal: got %b required %b", bus.err, exp_err);
    end
    wait_done(cyc);
    cyc = 0;
    pulse_start(W'(1), W'(1));
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b required 0", bus.err);
    end
    wait_done(cyc);
    checks++;
    if (bus.P !== W'(1) || bus.is_one !== 1'b1) begin
      errors++;
      $display("FAIL err_followup: P=%h is_one=%b required 1 1", bus.P, bus.is_one);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.C     = '0;
    reset     = 1'b1;
    test_reset();
    test_products();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
